wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline interface. Consumes the registered MEM/WB bundle:

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/wb_sel.sv | 41 ++++
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RegDst codes, instruction field positions, bubble encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  // RegDst codes carried in the MEM/WB bundle
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;
  localparam logic [1:0] REGDST_RSVD = 2'b11;

  // Register-index fields of the 32-bit instruction word
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  // An all-zero instruction word is a pipeline bubble
  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/wb_sel.sv
// Write-back selection: resolves destination index, write data and write enable.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever its inputs are.
module wb_sel
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic [RT_MSB-RD_LSB:0] dst_fields,  // instr[20:11]: rt field down to rd field
  input  logic [DATA_W-1:0]      mem_res,
  input  logic [DATA_W-1:0]      link_res,
  input  logic [1:0]             reg_dst,
  input  logic                   reg_write,
  output logic                   wb_en,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data
);

  localparam int RT_OFS = RT_LSB - RD_LSB;

  // Decode RegDst into a destination index and pick the write data source
  always_comb begin
    wb_addr = '0;
    wb_data = mem_res;
    case (reg_dst)
      REGDST_RT:   wb_addr = ADDR_W'(dst_fields[RT_MSB-RD_LSB:RT_OFS]);
      REGDST_RD:   wb_addr = ADDR_W'(dst_fields[RD_MSB-RD_LSB:0]);
      REGDST_LINK: begin
        wb_addr = ADDR_W'(LINK_REG);
        wb_data = link_res;
      end
      default:     wb_addr = '0;  // reserved code never writes
    endcase
  end

  // Index 0 is hardwired to zero, so a write aimed there is dropped here
  assign wb_en = reg_write && (reg_dst != REGDST_RSVD) && (wb_addr != '0);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32-entry GPR array, two async read ports, retire counter.
// Latency: writes land on the clock edge and are readable the next cycle (same cycle with WB_BYPASS_EN).
// Backpressure: none; every MEM/WB bundle is consumed the cycle it is presented.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] mem_res_i,
  input  logic [DATA_W-1:0] link_res_i,
  input  logic [1:0]        reg_dst_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              wb_en_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  wb_sel #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_wb_sel (
    .dst_fields (instr_i[RT_MSB:RD_LSB]),
    .mem_res    (mem_res_i),
    .link_res   (link_res_i),
    .reg_dst    (reg_dst_i),
    .reg_write  (reg_write_i),
    .wb_en      (wb_en_o),
    .wb_addr    (wb_addr_o),
    .wb_data    (wb_data_o)
  );

  // Commit the resolved write; reset clears the whole array and wins over any write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en_o) begin
      regs[wb_addr_o] <= wb_data_o;
    end
  end

  // Count every non-bubble instruction leaving the pipe; wraps naturally at full scale
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_o <= '0;
    end else if (instr_i != BUBBLE_INSTR) begin
      retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end

  // Read port A: index 0 reads zero; optional same-cycle forward of the pending write
  always_comb begin
    rs_data_o = regs[rs_addr_i];
`ifdef WB_BYPASS_EN
    if (wb_en_o && (rs_addr_i == wb_addr_o)) rs_data_o = wb_data_o;
`endif
    if (rs_addr_i == '0) rs_data_o = '0;
  end

  // Read port B: same rules as port A
  always_comb begin
    rt_data_o = regs[rt_addr_i];
`ifdef WB_BYPASS_EN
    if (wb_en_o && (rt_addr_i == wb_addr_o)) rt_data_o = wb_data_o;
`endif
    if (rt_addr_i == '0) rt_data_o = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed MEM/WB bundles, a per-cycle reference model and literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] mem_res;
  logic [31:0] link_res;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] retire_cnt;

  // narrow-counter instance, used to exercise counter wrap in a short run
  logic [31:0] n_rs_data, n_rt_data, n_wb_data;
  logic        n_wb_en;
  logic [4:0]  n_wb_addr;
  logic [3:0]  n_retire_cnt;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_i      (instr),
    .mem_res_i    (mem_res),
    .link_res_i   (link_res),
    .reg_dst_i    (reg_dst),
    .reg_write_i  (reg_write),
    .rs_addr_i    (rs_addr),
    .rt_addr_i    (rt_addr),
    .rs_data_o    (rs_data),
    .rt_data_o    (rt_data),
    .wb_en_o      (wb_en),
    .wb_addr_o    (wb_addr),
    .wb_data_o    (wb_data),
    .retire_cnt_o (retire_cnt)
  );

  wb_regfile #(.CNT_W(4)) u_narrow (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_i      (instr),
    .mem_res_i    (mem_res),
    .link_res_i   (link_res),
    .reg_dst_i    (reg_dst),
    .reg_write_i  (reg_write),
    .rs_addr_i    (rs_addr),
    .rt_addr_i    (rt_addr),
    .rs_data_o    (n_rs_data),
    .rt_data_o    (n_rt_data),
    .wb_en_o      (n_wb_en),
    .wb_addr_o    (n_wb_addr),
    .wb_data_o    (n_wb_data),
    .retire_cnt_o (n_retire_cnt)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  longint unsigned m_retired;   // retirements since last reset, unbounded

  function automatic int m_dest();
    if (reg_dst == 2'd0) return int'(instr[20:16]);
    if (reg_dst == 2'd1) return int'(instr[15:11]);
    if (reg_dst == 2'd2) return 31;
    return -1;
  endfunction

  function automatic bit m_we();
    return reg_write && m_dest() > 0;
  endfunction

  function automatic logic [31:0] m_wdata();
    return (reg_dst == 2'd2) ? link_res : mem_res;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (m_we() && int'(a) == m_dest()) return m_wdata();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_retired = 0;
    end else begin
      if (m_we()) m_regs[m_dest()] = m_wdata();
      if (instr != 32'h0) m_retired = m_retired + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      check("cyc rs_data", rs_data, m_read(rs_addr));
      check("cyc rt_data", rt_data, m_read(rt_addr));
      check("cyc wb_en", {31'h0, wb_en}, {31'h0, m_we()});
      if (m_we()) begin
        check("cyc wb_addr", {27'h0, wb_addr}, 32'(m_dest()));
        check("cyc wb_data", wb_data, m_wdata());
      end
      check("cyc retire_cnt", retire_cnt, 32'(m_retired));
      check("cyc narrow_cnt", {28'h0, n_retire_cnt}, 32'(m_retired % 16));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [31:0] ins, input logic [1:0] dst,
                       input logic we, input logic [31:0] mem, input logic [31:0] lnk,
                       input logic [4:0] ra, input logic [4:0] rb);
    rst = r; instr = ins; reg_dst = dst; reg_write = we;
    mem_res = mem; link_res = lnk; rs_addr = ra; rt_addr = rb;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(posedge clk); #1;
    tick();
    checking = 1'b1;

    // 1: everything reads zero after reset
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      check("reset rs", rs_data, 32'h0);
      check("reset rt", rt_data, 32'h0);
      tick();
    end
    check("reset cnt", retire_cnt, 32'h0);

    // 2: rd-destination write
    drive(1'b0, 32'h012A4020, 2'd1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0);
    check("rd wb_en", {31'h0, wb_en}, 32'h1);
    check("rd wb_addr", {27'h0, wb_addr}, 32'd8);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd8);
    check("rd readback rs", rs_data, 32'hDEADBEEF);
    check("rd readback rt", rt_data, 32'hDEADBEEF);
    check("rd retire", retire_cnt, 32'd1);
    tick();

    // 3: link write ignores mem_res
    drive(1'b0, 32'h0C000004, 2'd2, 1'b1, 32'h12345678, 32'h00400010, 5'd0, 5'd0);
    check("link wb_addr", {27'h0, wb_addr}, 32'd31);
    check("link wb_data", wb_data, 32'h00400010);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd8);
    check("link readback", rs_data, 32'h00400010);
    check("link keeps r8", rt_data, 32'hDEADBEEF);
    tick();

    // 4: write to index 0 is dropped
    drive(1'b0, 32'h20000000, 2'd0, 1'b1, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    check("r0 wb_en", {31'h0, wb_en}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    check("r0 read", rs_data, 32'h0);
    check("r0 retire", retire_cnt, 32'd3);
    tick();

    // 5: same-cycle write and read of index 5
    drive(1'b0, 32'h00050000, 2'd0, 1'b1, 32'hA5A5A5A5, 32'h0, 5'd5, 5'd0);
`ifdef WB_BYPASS_EN
    check("same-cycle r5", rs_data, 32'hA5A5A5A5);
`else
    check("same-cycle r5", rs_data, 32'h0);
`endif
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
    check("next-cycle r5", rs_data, 32'hA5A5A5A5);
    tick();

    // reserved RegDst: no write, still retires
    drive(1'b0, 32'h012A4020, 2'd3, 1'b1, 32'h55555555, 32'h66666666, 5'd8, 5'd10);
    check("rsvd wb_en", {31'h0, wb_en}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd10);
    check("rsvd r8 kept", rs_data, 32'hDEADBEEF);
    check("rsvd r10 kept", rt_data, 32'h0);
    check("rsvd retire", retire_cnt, 32'd5);
    tick();

    // 6: reset beats a concurrent write and retire
    drive(1'b0, 32'h00090000, 2'd0, 1'b1, 32'h00000099, 32'h0, 5'd9, 5'd0);
    tick();
    drive(1'b1, 32'h00090000, 2'd0, 1'b1, 32'h11112222, 32'h0, 5'd9, 5'd0);
    check("rst wb_en ungated", {31'h0, wb_en}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd31);
    check("rst r9", rs_data, 32'h0);
    check("rst r31", rt_data, 32'h0);
    check("rst cnt", retire_cnt, 32'h0);
    check("rst narrow cnt", {28'h0, n_retire_cnt}, 32'h0);
    tick();

    // counter wrap on the 4-bit instance, with varied register traffic
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, {11'h0, 5'(i + 1), 16'h0}, 2'd0, i[0], 32'(i * 32'h01010101), 32'h0,
            5'(i), 5'(i + 1));
      tick();
      if (i == 14) begin
        drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("narrow at 15", {28'h0, n_retire_cnt}, 32'd15);
      end
    end
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd16, 5'd15);
    check("narrow wrapped", {28'h0, n_retire_cnt}, 32'h0);
    check("wide no wrap", retire_cnt, 32'd16);
    check("r16 written", rs_data, 32'h0F0F0F0F);
    check("r15 untouched", rt_data, 32'h0);
    tick();
    tick();

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
